// File: rtl/ia_upscale_reader_if.sv
// Image-RAM read port of the upscale reader: read strobe and word address out,
// 10-bit data back exactly one cycle after the strobe.
interface ia_upscale_reader_if;
  logic        rd;
  logic [15:0] addr;
  logic [9:0]  data;
  modport master (output rd, addr, input data);
  modport slave  (input rd, addr, output data);
endinterface

// File: rtl/ia_upscale_reader.sv
// Reads the planar 128x128 image from RAM, replicates it 3x3 and overlays it on the
// 640x480 VGA stream inside a fixed window; live camera pixels pass through elsewhere.
module ia_upscale_reader #(
  parameter int H_SYNC_CYC  = 96,
  parameter int H_SYNC_BACK = 48,
  parameter int H_TOTAL     = 800,
  parameter int H_ITP_START = 128,
  parameter int V_SYNC_CYC  = 2,
  parameter int V_SYNC_BACK = 33,
  parameter int V_TOTAL     = 525,
  parameter int V_ITP_START = 48,
  parameter int ITP_RANGE   = 384
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_start,
  input  logic [9:0]                 i_Red,
  input  logic [9:0]                 i_Green,
  input  logic [9:0]                 i_Blue,
  ia_upscale_reader_if.master        mem,
  output logic                       o_hsync,
  output logic                       o_vsync,
  output logic [9:0]                 o_R,
  output logic [9:0]                 o_G,
  output logic [9:0]                 o_B,
  output logic                       o_busy,
  output logic                       o_done
);
  localparam logic [9:0] XS     = 10'(H_SYNC_CYC + H_SYNC_BACK + H_ITP_START);
  localparam logic [9:0] XE     = 10'(H_SYNC_CYC + H_SYNC_BACK + H_ITP_START + ITP_RANGE);
  localparam logic [9:0] YS     = 10'(V_SYNC_CYC + V_SYNC_BACK + V_ITP_START);
  localparam logic [9:0] YE     = 10'(V_SYNC_CYC + V_SYNC_BACK + V_ITP_START + ITP_RANGE);
  localparam logic [9:0] RD_PRE = XS - 10'd4;
  localparam logic [9:0] RD_LO  = XS - 10'd3;
  localparam logic [9:0] RD_HI  = XE - 10'd4;
  localparam logic [9:0] Y_PRE  = YS - 10'd1;
  localparam logic [9:0] H_END  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_END  = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS_W   = 10'(H_SYNC_CYC);
  localparam logic [9:0] VS_W   = 10'(V_SYNC_CYC);

  typedef enum logic [1:0] {IDLE, ARMED, SHOW} state_e;

  state_e      state_q, state_d;
  logic        pend_q, pend_d;
  logic [9:0]  h_q, v_q;
  logic [1:0]  ph_q, vph_q, ph_dly_q;
  logic [6:0]  col_q, row_q;
  logic        rd_dly_q;
  logic [9:0]  r_stg_q, g_stg_q, pr_q, pg_q, pb_q;
  logic [15:0] addr_q;
  logic        frame_end, row_span, rd_span, in_win, mem_rd, b_ret;
  logic [15:0] addr_now;
  logic [9:0]  px_r, px_g, px_b;

  assign frame_end = (h_q == H_END) && (v_q == V_END);
  assign row_span  = (v_q >= YS) && (v_q < YE);
  assign rd_span   = (h_q >= RD_LO) && (h_q <= RD_HI);
  assign in_win    = (state_q == SHOW) && row_span && (h_q >= XS) && (h_q < XE);
  assign mem_rd    = (state_q == SHOW) && row_span && rd_span;
  // Plane in the top two bits gives plane*16384 + row*128 + col without arithmetic.
  assign addr_now  = {ph_q, row_q, col_q};
  assign mem.rd    = mem_rd;
  assign mem.addr  = mem_rd ? addr_now : addr_q;
  assign o_busy    = (state_q != IDLE);

  // The B word lands in the first cycle a column is displayed, so bypass the pixel register then.
  assign b_ret = rd_dly_q && (ph_dly_q == 2'd2);
  assign px_r  = b_ret ? r_stg_q  : pr_q;
  assign px_g  = b_ret ? g_stg_q  : pg_q;
  assign px_b  = b_ret ? mem.data : pb_q;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    case (state_q)
      IDLE:  if (i_start) state_d = ARMED;
      ARMED: begin
        if (i_start)   pend_d  = 1'b1;
        if (frame_end) state_d = SHOW;
      end
      SHOW: begin
        if (frame_end) begin
          state_d = (pend_q || i_start) ? ARMED : IDLE;
          pend_d  = 1'b0;
        end else if (i_start) begin
          pend_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      h_q     <= '0;
      v_q     <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      if (h_q == H_END) begin
        h_q <= '0;
        v_q <= (v_q == V_END) ? 10'd0 : v_q + 10'd1;
      end else begin
        h_q <= h_q + 10'd1;
      end
    end
  end

  // Phase/step counters replace the /3 for column and row.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ph_q  <= '0;
      col_q <= '0;
      vph_q <= '0;
      row_q <= '0;
    end else begin
      if (h_q == RD_PRE) begin
        ph_q  <= '0;
        col_q <= '0;
      end else if (rd_span) begin
        if (ph_q == 2'd2) begin
          ph_q  <= '0;
          col_q <= col_q + 7'd1;
        end else begin
          ph_q <= ph_q + 2'd1;
        end
      end
      if (h_q == H_END) begin
        if (v_q == Y_PRE) begin
          vph_q <= '0;
          row_q <= '0;
        end else if (row_span) begin
          if (vph_q == 2'd2) begin
            vph_q <= '0;
            row_q <= row_q + 7'd1;
          end else begin
            vph_q <= vph_q + 2'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_dly_q <= 1'b0;
      ph_dly_q <= '0;
      addr_q   <= '0;
      r_stg_q  <= '0;
      g_stg_q  <= '0;
      pr_q     <= '0;
      pg_q     <= '0;
      pb_q     <= '0;
    end else begin
      rd_dly_q <= mem_rd;
      ph_dly_q <= ph_q;
      if (mem_rd) addr_q <= addr_now;
      if (rd_dly_q && ph_dly_q == 2'd0) r_stg_q <= mem.data;
      if (rd_dly_q && ph_dly_q == 2'd1) g_stg_q <= mem.data;
      if (b_ret) begin
        pr_q <= r_stg_q;
        pg_q <= g_stg_q;
        pb_q <= mem.data;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_hsync <= 1'b1;
      o_vsync <= 1'b1;
      o_R     <= '0;
      o_G     <= '0;
      o_B     <= '0;
      o_done  <= 1'b0;
    end else begin
      o_hsync <= (h_q >= HS_W);
      o_vsync <= (v_q >= VS_W);
      o_done  <= (state_q == SHOW) && frame_end;
      if (in_win) begin
        o_R <= px_r;
        o_G <= px_g;
        o_B <= px_b;
      end else begin
        o_R <= i_Red;
        o_G <= i_Green;
        o_B <= i_Blue;
      end
    end
  end
endmodule

// File: tb/tb_ia_upscale_reader.sv
// Bench for ia_upscale_reader on a shrunken raster (8x8 image, 24x24 window) so whole
// frames are short; every output is compared each cycle against an arithmetic model.
module tb_ia_upscale_reader;
  localparam int HSC = 4, HSB = 3, HT = 60, HIS = 5;
  localparam int VSC = 2, VSB = 2, VT = 40, VIS = 3, ITP = 24;
  localparam int XS = HSC + HSB + HIS;
  localparam int YS = VSC + VSB + VIS;
  localparam int FRAME = HT * VT;
  localparam logic [50:0] RST_V = {2'b11, 49'b0};

  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0;
  logic [9:0] red = '0, green = '0, blue = '0;
  logic hs, vs, busy, done;
  logic [9:0] oR, oG, oB;
  logic [9:0] ram [0:49151];

  ia_upscale_reader_if mif();

  ia_upscale_reader #(
    .H_SYNC_CYC(HSC), .H_SYNC_BACK(HSB), .H_TOTAL(HT), .H_ITP_START(HIS),
    .V_SYNC_CYC(VSC), .V_SYNC_BACK(VSB), .V_TOTAL(VT), .V_ITP_START(VIS),
    .ITP_RANGE(ITP)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .i_Red(red), .i_Green(green), .i_Blue(blue),
    .mem(mif),
    .o_hsync(hs), .o_vsync(vs), .o_R(oR), .o_G(oG), .o_B(oB),
    .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mif.rd) mif.data <= ram[mif.addr];

  // Reference model: raster position, frame mode (0 idle, 1 armed, 2 show), pixel lookup by division.
  int m_h, m_v, m_mode, m_idx, m_j;
  bit m_pend, m_fend, m_win;
  logic [15:0] m_last, e_addr;
  logic e_rd, e_hs, e_vs, e_done;
  logic [9:0] e_R, e_G, e_B;

  always_comb begin
    m_fend = (m_h == HT - 1) && (m_v == VT - 1);
    m_win  = (m_mode == 2) && m_h >= XS && m_h < XS + ITP && m_v >= YS && m_v < YS + ITP;
    m_idx  = ((m_v - YS) / 3) * 128 + (m_h - XS) / 3;
    e_rd   = (m_mode == 2) && m_v >= YS && m_v < YS + ITP && m_h >= XS - 3 && m_h < XS + ITP - 3;
    m_j    = m_h - (XS - 3);
    e_addr = e_rd ? 16'((m_j % 3) * 16384 + ((m_v - YS) / 3) * 128 + m_j / 3) : m_last;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_h <= 0; m_v <= 0; m_mode <= 0; m_pend <= 1'b0; m_last <= '0;
      e_hs <= 1'b1; e_vs <= 1'b1; e_done <= 1'b0;
      e_R <= '0; e_G <= '0; e_B <= '0;
    end else begin
      m_h <= (m_h == HT - 1) ? 0 : m_h + 1;
      if (m_h == HT - 1) m_v <= (m_v == VT - 1) ? 0 : m_v + 1;
      if (e_rd) m_last <= e_addr;
      e_hs   <= (m_h >= HSC);
      e_vs   <= (m_v >= VSC);
      e_done <= (m_mode == 2) && m_fend;
      if (m_win) begin
        e_R <= ram[m_idx]; e_G <= ram[m_idx + 16384]; e_B <= ram[m_idx + 32768];
      end else begin
        e_R <= red; e_G <= green; e_B <= blue;
      end
      case (m_mode)
        0: if (start) m_mode <= 1;
        1: begin
          if (start) m_pend <= 1'b1;
          if (m_fend) m_mode <= 2;
        end
        default: begin
          if (m_fend) begin
            m_mode <= (m_pend || start) ? 1 : 0;
            m_pend <= 1'b0;
          end else if (start) m_pend <= 1'b1;
        end
      endcase
    end
  end

  logic [50:0] obs, expv;
  assign obs  = {hs, vs, busy, done, mif.rd, mif.addr, oR, oG, oB};
  assign expv = {e_hs, e_vs, (m_mode != 0), e_done, e_rd, e_addr, e_R, e_G, e_B};

  int vecs = 0, errs = 0, nprint = 0;

  task automatic shake();
    red = 10'($urandom); green = 10'($urandom); blue = 10'($urandom);
  endtask

  task automatic load_ram();
    for (int i = 0; i < 49152; i++) ram[i] = 10'($urandom);
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1 vecs++;
    if (obs !== RST_V) begin errs++; $display("FAIL reset_async got %h want %h", obs, RST_V); end
    repeat (3) begin
      @(negedge clk); vecs++;
      if (obs !== expv) begin errs++; $display("FAIL reset_hold got %h want %h", obs, expv); end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_idle();
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk); vecs++;
      if (obs !== expv) begin
        errs++;
        if (nprint++ < 10) $display("FAIL idle h=%0d v=%0d got %h want %h", m_h, m_v, obs, expv);
      end
      shake();
    end
  endtask

  task automatic test_frame();
    bit started = 0, fin = 0, seen_rd = 0;
    int nd = 0;
    for (int c = 0; c < 3 * FRAME; c++) begin
      @(negedge clk); vecs++;
      if (obs !== expv) begin
        errs++;
        if (nprint++ < 10) $display("FAIL frame h=%0d v=%0d got %h want %h", m_h, m_v, obs, expv);
      end
      if (mif.rd && !seen_rd) begin
        seen_rd = 1; vecs++;
        if (m_h != XS - 3 || m_v != YS || mif.addr !== 16'd0) begin
          errs++;
          $display("FAIL first_rd at h=%0d v=%0d addr=%0d want h=%0d v=%0d addr=0", m_h, m_v, mif.addr, XS - 3, YS);
        end
      end
      nd += int'(done);
      if (started && m_mode == 0) begin fin = 1; break; end
      start = (!started && m_v == 10);
      if (start) started = 1;
      shake();
    end
    start = 1'b0;
    vecs++;
    if (!fin || nd != 1) begin errs++; $display("FAIL frame_done count=%0d want 1 finished=%0d", nd, fin); end
  endtask

  task automatic test_back_to_back();
    bit fin = 0;
    int nd = 0, ns = 0;
    load_ram();
    for (int c = 0; c < 5 * FRAME; c++) begin
      @(negedge clk); vecs++;
      if (obs !== expv) begin
        errs++;
        if (nprint++ < 10) $display("FAIL b2b h=%0d v=%0d got %h want %h", m_h, m_v, obs, expv);
      end
      nd += int'(done);
      if (ns == 3 && m_mode == 0) begin fin = 1; break; end
      start = 1'b0;
      if (ns == 0) begin start = 1'b1; ns = 1; end
      else if (ns < 3 && m_mode == 2 && m_v == YS + 2 && (m_h == XS || m_h == XS + 10)) begin
        start = 1'b1; ns++;
      end
      shake();
    end
    start = 1'b0;
    vecs++;
    if (!fin || nd != 2) begin errs++; $display("FAIL b2b_done count=%0d want 2 finished=%0d", nd, fin); end
  endtask

  task automatic test_start_at_end();
    bit fin = 0;
    int nd = 0, ns = 0;
    for (int c = 0; c < 5 * FRAME; c++) begin
      @(negedge clk); vecs++;
      if (obs !== expv) begin
        errs++;
        if (nprint++ < 10) $display("FAIL end_start h=%0d v=%0d got %h want %h", m_h, m_v, obs, expv);
      end
      nd += int'(done);
      if (ns == 2 && m_mode == 0) begin fin = 1; break; end
      start = 1'b0;
      if (ns == 0) begin start = 1'b1; ns = 1; end
      else if (ns == 1 && m_mode == 2 && m_h == HT - 1 && m_v == VT - 1) begin start = 1'b1; ns = 2; end
      shake();
    end
    start = 1'b0;
    vecs++;
    if (!fin || nd != 2) begin errs++; $display("FAIL end_start_done count=%0d want 2 finished=%0d", nd, fin); end
  endtask

  task automatic test_reset_mid();
    bit hit = 0;
    int nd = 0;
    start = 1'b1;
    for (int c = 0; c < 3 * FRAME; c++) begin
      @(negedge clk); vecs++;
      if (obs !== expv) begin
        errs++;
        if (nprint++ < 10) $display("FAIL pre_rst h=%0d v=%0d got %h want %h", m_h, m_v, obs, expv);
      end
      start = 1'b0;
      shake();
      if (m_mode == 2 && m_v == YS + 4 && m_h == XS + 7) begin hit = 1; break; end
    end
    #2 rst_n = 1'b0;
    #1 vecs++;
    if (!hit || obs !== RST_V) begin errs++; $display("FAIL mid_rst got %h want %h reached=%0d", obs, RST_V, hit); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < FRAME + 20; c++) begin
      @(negedge clk); vecs++;
      if (obs !== expv) begin
        errs++;
        if (nprint++ < 10) $display("FAIL post_rst h=%0d v=%0d got %h want %h", m_h, m_v, obs, expv);
      end
      nd += int'(done);
      shake();
    end
    vecs++;
    if (nd != 0 || busy !== 1'b0) begin errs++; $display("FAIL post_rst_idle done=%0d busy=%b want 0 0", nd, busy); end
  endtask

  initial begin
    load_ram();
    test_reset();
    test_idle();
    test_frame();
    test_back_to_back();
    test_start_at_end();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
